// File: rtl/drp_pkg.sv
// Shared DRP definitions: bus widths, out-of-range read data, responder FSM states.
package drp_pkg;
  localparam int DRP_ADDR_W = 8;
  localparam int DRP_DATA_W = 16;
  localparam logic [DRP_DATA_W-1:0] DRP_OOR_RDATA = 16'h0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} drp_state_e;
endpackage

// File: rtl/drp_regbank.sv
// DEPTH x 16 register bank: async read, sync write, out-of-range accesses
// read DRP_OOR_RDATA and drop writes.
module drp_regbank
  import drp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter logic [DRP_DATA_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DRP_ADDR_W-1:0] waddr,
  input  logic [DRP_DATA_W-1:0] wdata,
  input  logic [DRP_ADDR_W-1:0] raddr,
  output logic [DRP_DATA_W-1:0] rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DRP_DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [DRP_ADDR_W-1:0] a);
    return {1'b0, a} < 9'(DEPTH);
  endfunction

  assign rdata = in_range(raddr) ? mem[raddr[AW-1:0]] : DRP_OOR_RDATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (we && in_range(waddr)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/drp_responder.sv
// DRP slave with fixed LATENCY response and overlap detection.
// Optional DRP_RESPONDER_ERR_CNT_EN adds a saturating err_cnt output.
module drp_responder
  import drp_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH = 64,
  parameter logic [DRP_DATA_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drp_en,
  input  logic                  drp_we,
  input  logic [DRP_ADDR_W-1:0] drp_addr,
  input  logic [DRP_DATA_W-1:0] drp_di,
  output logic [DRP_DATA_W-1:0] drp_do,
  output logic                  drp_rdy,
  output logic                  busy,
  output logic                  err_overlap
`ifdef DRP_RESPONDER_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);
  drp_state_e            state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DRP_ADDR_W-1:0] addr_q;
  logic [DRP_DATA_W-1:0] di_q;
  logic [DRP_ADDR_W-1:0] raddr;
  logic [DRP_DATA_W-1:0] rdata;

  // With LATENCY=1 read data is taken in the accept cycle, before addr_q is valid.
  assign raddr = (state == IDLE) ? drp_addr : addr_q;

  drp_regbank #(.DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) u_regbank (
    .clk   (clk),
    .rst   (rst),
    .we    ((state == RESPOND) && we_q),
    .waddr (addr_q),
    .wdata (di_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      di_q        <= '0;
      drp_do      <= '0;
      drp_rdy     <= 1'b0;
      busy        <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      drp_rdy     <= 1'b0;
      err_overlap <= 1'b0;
      case (state)
        IDLE: if (drp_en) begin
          we_q   <= drp_we;
          addr_q <= drp_addr;
          di_q   <= drp_di;
          busy   <= 1'b1;
          if (LATENCY == 1) begin
            state   <= RESPOND;
            cnt     <= '0;
            drp_rdy <= 1'b1;
            if (!drp_we) drp_do <= rdata;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          err_overlap <= drp_en;
          if (cnt == 4'd1) begin
            state   <= RESPOND;
            cnt     <= '0;
            drp_rdy <= 1'b1;
            if (!we_q) drp_do <= rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          // Write commits on this edge via the regbank write port.
          err_overlap <= drp_en;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRP_RESPONDER_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (err_overlap && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_drp_responder.sv
// Directed table-driven bench for drp_responder (LATENCY=3 and LATENCY=1 instances).
module tb_drp_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en3 = 0, we3 = 0;
  logic [7:0]  addr3 = 0;
  logic [15:0] di3 = 0, do3;
  logic        rdy3, busy3, err3;
  logic        en1 = 0, we1 = 0;
  logic [7:0]  addr1 = 0;
  logic [15:0] di1 = 0, do1;
  logic        rdy1, busy1, err1;
`ifdef DRP_RESPONDER_ERR_CNT_EN
  logic [7:0]  ecnt3, ecnt1;
`endif

  drp_responder #(.LATENCY(3), .DEPTH(64), .RESET_VAL(16'h5A5A)) dut3 (
    .clk(clk), .rst(rst), .drp_en(en3), .drp_we(we3), .drp_addr(addr3), .drp_di(di3),
    .drp_do(do3), .drp_rdy(rdy3), .busy(busy3), .err_overlap(err3)
`ifdef DRP_RESPONDER_ERR_CNT_EN
    , .err_cnt(ecnt3)
`endif
  );

  drp_responder #(.LATENCY(1), .DEPTH(16), .RESET_VAL(16'hC3C3)) dut1 (
    .clk(clk), .rst(rst), .drp_en(en1), .drp_we(we1), .drp_addr(addr1), .drp_di(di1),
    .drp_do(do1), .drp_rdy(rdy1), .busy(busy1), .err_overlap(err1)
`ifdef DRP_RESPONDER_ERR_CNT_EN
    , .err_cnt(ecnt1)
`endif
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] di;
    logic [15:0] exp;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [15:0] last_do = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rdy3 is seen (lat=0 on timeout).
  task automatic txn3(input logic w, input logic [7:0] a, input logic [15:0] d, output int lat);
    en3 = 1; we3 = w; addr3 = a; di3 = d;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      en3 = 0;
      if (rdy3) begin lat = k; break; end
      chk("busy3_wait", busy3, 1);
    end
  endtask

  task automatic txn1(input logic w, input logic [7:0] a, input logic [15:0] d, output int lat);
    en1 = 1; we1 = w; addr1 = a; di1 = d;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      en1 = 0;
      if (rdy1) begin lat = k; break; end
    end
  endtask

  vec_t vecs[14];

  initial begin
    int lat;
    vecs[0]  = '{0, 8'h05, 16'h0000, 16'h5A5A};
    vecs[1]  = '{1, 8'h05, 16'hA5A5, 16'h0000};
    vecs[2]  = '{0, 8'h05, 16'h0000, 16'hA5A5};
    vecs[3]  = '{1, 8'h3F, 16'hFFFF, 16'h0000};
    vecs[4]  = '{0, 8'h3F, 16'h0000, 16'hFFFF};
    vecs[5]  = '{0, 8'h00, 16'h0000, 16'h5A5A};
    vecs[6]  = '{1, 8'h80, 16'h1234, 16'h0000};
    vecs[7]  = '{0, 8'h80, 16'h0000, 16'h0000};
    vecs[8]  = '{0, 8'hFF, 16'h0000, 16'h0000};
    vecs[9]  = '{1, 8'h40, 16'h0001, 16'h0000};
    vecs[10] = '{0, 8'h40, 16'h0000, 16'h0000};
    vecs[11] = '{0, 8'h3E, 16'h0000, 16'h5A5A};
    vecs[12] = '{1, 8'h00, 16'h0102, 16'h0000};
    vecs[13] = '{0, 8'h00, 16'h0000, 16'h0102};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_rdy", rdy3, 0);
    chk("rst_do", do3, 16'h0000);
    chk("rst_busy", busy3, 0);
    chk("rst_err", err3, 0);
    rst = 0;

    // Table: first request issued right at reset release; back-to-back at LATENCY+1
    for (int i = 0; i < 14; i++) begin
      txn3(vecs[i].we, vecs[i].addr, vecs[i].di, lat);
      chk($sformatf("lat[%0d]", i), lat, 3);
      if (!vecs[i].we) last_do = vecs[i].exp;
      chk($sformatf("do[%0d]", i), do3, last_do);
      chk($sformatf("err[%0d]", i), err3, 0);
      @(negedge clk);
      chk($sformatf("rdy_pulse[%0d]", i), rdy3, 0);
      chk($sformatf("idle_busy[%0d]", i), busy3, 0);
      chk($sformatf("do_hold[%0d]", i), do3, last_do);
    end

    // Overlap: second en one cycle after the first is ignored and flagged
    en3 = 1; we3 = 0; addr3 = 8'h05; di3 = 16'h0000;
    @(negedge clk);
    chk("ov_busy", busy3, 1);
    we3 = 1; di3 = 16'h1111;
    @(negedge clk);
    en3 = 0;
    chk("ov_err_pulse", err3, 1);
    chk("ov_rdy_early", rdy3, 0);
    @(negedge clk);
    chk("ov_rdy", rdy3, 1);
    chk("ov_do", do3, 16'hA5A5);
    chk("ov_err_clear", err3, 0);
    @(negedge clk);
    chk("ov_single_rdy", rdy3, 0);
`ifdef DRP_RESPONDER_ERR_CNT_EN
    chk("ov_err_cnt", ecnt3, 1);
`endif
    txn3(0, 8'h05, 16'h0, lat);
    chk("ov_nowrite_lat", lat, 3);
    chk("ov_nowrite_do", do3, 16'hA5A5);
    @(negedge clk);

    // Reset during WAIT aborts the write
    en3 = 1; we3 = 1; addr3 = 8'h02; di3 = 16'hDEAD;
    @(negedge clk);
    en3 = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_rdy", rdy3, 0);
    chk("abort_busy", busy3, 0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rdy", rdy3, 0);
    end
    txn3(0, 8'h02, 16'h0, lat);
    chk("abort_lat", lat, 3);
    chk("abort_do", do3, 16'h5A5A);
    @(negedge clk);

    // LATENCY=1 back-to-back reads every 2 cycles
    for (int i = 0; i < 4; i++) begin
      txn1(0, 8'h00, 16'h0, lat);
      chk($sformatf("l1_lat[%0d]", i), lat, 1);
      chk($sformatf("l1_do[%0d]", i), do1, 16'hC3C3);
      @(negedge clk);
      chk($sformatf("l1_err[%0d]", i), err1, 0);
      chk($sformatf("l1_idle[%0d]", i), busy1, 0);
    end
    txn1(1, 8'h0F, 16'h7E57, lat);
    chk("l1_wr_lat", lat, 1);
    chk("l1_wr_do", do1, 16'hC3C3);
    @(negedge clk);
    txn1(0, 8'h0F, 16'h0, lat);
    chk("l1_raw_do", do1, 16'h7E57);
    @(negedge clk);
    txn1(0, 8'h10, 16'h0, lat);
    chk("l1_oor_lat", lat, 1);
    chk("l1_oor_do", do1, 16'h0000);
    @(negedge clk);

`ifdef DRP_RESPONDER_ERR_CNT_EN
    // Continuous en: three violations per four cycles, well over 300 in 500 cycles
    en3 = 1; we3 = 0; addr3 = 8'h00;
    for (int k = 0; k < 500; k++) @(negedge clk);
    en3 = 0;
    @(negedge clk); @(negedge clk);
    chk("err_cnt_sat", ecnt3, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/drp_responder.md
DRP_RESPONDER -- requirements
Module: drp_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, cycles from accepted drp_en to drp_rdy (legal 1..15).
REQ-002 SHALL have parameter DEPTH, default 64, number of implemented 16-bit registers at addresses 0..DEPTH-1 (legal 1..256).
REQ-003 SHALL have parameter RESET_VAL, default 16'h0000, reset content of every register.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge DRP clock; rst input 1, async active-high reset.
REQ-005 SHALL have drp_en input 1, transaction request, single-cycle strobe.
REQ-006 SHALL have drp_we input 1, 1 means write and 0 means read; sampled with drp_en.
REQ-007 SHALL have drp_addr input 8, register address; sampled with drp_en.
REQ-008 SHALL have drp_di input 16, write data; sampled with drp_en.
REQ-009 SHALL have drp_do output 16, read data.
REQ-010 SHALL have drp_rdy output 1, one-cycle completion pulse.
REQ-011 SHALL have busy output 1, high while a transaction is outstanding.
REQ-012 SHALL have err_overlap output 1, one-cycle pulse flagging a protocol violation.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESPOND.
REQ-014 SHALL accept drp_en only in IDLE; on acceptance it captures we, addr and di, loads the latency counter with LATENCY-1, and enters WAIT, or enters RESPOND directly if LATENCY=1.
REQ-015 WAIT SHALL decrement the counter each cycle and enter RESPOND on the cycle the counter reaches 0.
REQ-016 RESPOND SHALL assert drp_rdy for exactly one cycle and return to IDLE on the next cycle.
REQ-017 SHALL assert drp_rdy exactly LATENCY cycles after the drp_en cycle (en at edge N gives rdy high during cycle N+LATENCY).
REQ-018 On read, SHALL drive drp_do with mem[addr] during the drp_rdy cycle.
REQ-019 drp_do SHALL hold its last value outside rdy cycles.
REQ-020 On write, SHALL commit mem[addr] <= di at the rdy cycle edge and leave drp_do unchanged.
REQ-021 On an out-of-range address (addr >= DEPTH), a read SHALL return 16'h0000, a write SHALL be discarded, and drp_rdy SHALL still be issued.
REQ-022 drp_en high in WAIT or RESPOND SHALL be ignored, pulse err_overlap the following cycle, and leave the outstanding transaction unaffected.
REQ-023 busy SHALL be high in WAIT and RESPOND and low in IDLE.
REQ-024 A read issued after a write to the same address SHALL return the written value, with no hazard window.
REQ-025 drp_en on the first IDLE cycle after RESPOND SHALL be accepted, giving back-to-back throughput of LATENCY+1 cycles.

Reset
REQ-026 When rst is asserted, SHALL set state to IDLE, drp_rdy to 0, drp_do to 16'h0000, busy to 0, err_overlap to 0, the counter to 0, and every register to RESET_VAL.
REQ-027 Reset mid-transaction SHALL abort the transaction: no drp_rdy is issued and no write is committed.
REQ-028 The first drp_en SHALL be accepted on the first clk edge after rst is released.

Configuration
REQ-029 With macro DRP_RESPONDER_ERR_CNT_EN defined, SHALL add output err_cnt [7:0], which increments on each err_overlap pulse, saturates at 8'hFF, and resets to 0.
REQ-030 Without DRP_RESPONDER_ERR_CNT_EN, err_cnt and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 SHALL take the following from shared package drp_pkg: the FSM state enum, DRP_ADDR_W=8, DRP_DATA_W=16, and DRP_OOR_RDATA=16'h0000.
REQ-032 SHALL place storage in sub-module drp_regbank (DEPTH x 16, sync write, async read, range check), with the FSM and counter in drp_responder.

Verification
REQ-033 With LATENCY=3, a write of addr 8'h05, di 16'hA5A5 at cycle 10 SHALL produce drp_rdy in cycle 13; a read of 8'h05 at cycle 14 SHALL produce drp_rdy in cycle 17 with drp_do=16'hA5A5.
REQ-034 With LATENCY=1, back-to-back reads of 8'h00 issued every 2 cycles SHALL each give drp_rdy exactly 1 cycle later with drp_do=RESET_VAL, and err_overlap SHALL stay 0.
REQ-035 With DEPTH=64, a write of 8'h80 with 16'h1234 followed by a read of 8'h80 SHALL give drp_rdy on both and drp_do=16'h0000.
REQ-036 With LATENCY=3, a second drp_en 1 cycle after the first SHALL produce a single drp_rdy for the first transaction and an err_overlap pulse, and err_cnt=1 when the macro is defined.
REQ-037 A write to 8'h02 with rst asserted during WAIT SHALL produce no drp_rdy, and a later read of 8'h02 SHALL return RESET_VAL.
REQ-038 With the macro defined, 300 overlap violations SHALL leave err_cnt at 8'hFF.
